// File: rtl/alu_sequencer_if.sv
// Command handshake and ALU operand bus shared by the sequencer and its host.
// The slave side is the sequencer; the master side is the host that issues
// commands together with the external combinational ALU that returns alu_result.
interface alu_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  localparam int CMD_W = 3 + 3 * ADDR_W;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op_code;
  logic [DATA_W-1:0] alu_result;

  modport master (
    output cmd_valid, cmd, alu_result,
    input  cmd_ready, alu_a, alu_b, alu_op_code
  );

  modport slave (
    input  cmd_valid, cmd, alu_result,
    output cmd_ready, alu_a, alu_b, alu_op_code
  );
endinterface

// File: rtl/alu_sequencer.sv
// Register-file controller for an external combinational ALU.
// Each command runs IDLE -> FETCH -> EXEC -> WB: operands are read in FETCH,
// the ALU result is captured at the end of EXEC and written back in WB.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds zero_flag/neg_flag outputs.
module alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    bus,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        op_code,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              neg_flag
`endif
);
  localparam int CMD_W = 3 + 3 * ADDR_W;

  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] srca_q, srcb_q, dst_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q;
  logic              cmd_ready_w;
  logic              accept_w;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  // A host load in IDLE takes priority over accepting a command.
  assign cmd_ready_w   = (state_q == IDLE) && !ld_en;
  assign accept_w      = bus.cmd_valid && cmd_ready_w;
  assign bus.cmd_ready = cmd_ready_w;

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op_code = {1'b0, op_q};
  assign op_code         = op_q;
  assign result          = result_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == WB);
  assign rd_data         = regs_q[rd_addr];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: only leaving IDLE waits for an accepted command.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_w) state_d = FETCH;
      FETCH:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register-file write port shared by host loads (IDLE) and writeback (WB).
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = ld_addr;
    wr_data_d = ld_data;
    if (state_q == IDLE && ld_en) begin
      wr_en_d = 1'b1;
    end else if (state_q == WB && op_q != OP_NOP) begin
      wr_en_d   = 1'b1;
      wr_addr_d = dst_q;
      wr_data_d = result_q;
    end
  end

  // Register file; cleared by reset so a dropped command leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en_d) begin
      regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  // Command latch, operand fetch and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      dst_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept_w) begin
          op_q   <= bus.cmd[CMD_W-1 -: 3];
          srca_q <= bus.cmd[3*ADDR_W-1 -: ADDR_W];
          srcb_q <= bus.cmd[2*ADDR_W-1 -: ADDR_W];
          dst_q  <= bus.cmd[ADDR_W-1:0];
        end
        FETCH: begin
          alu_a_q <= regs_q[srca_q];
          // Single-operand ops see a clean zero on B.
          alu_b_q <= (op_q == OP_NOT || op_q == OP_MOV) ? '0 : regs_q[srcb_q];
        end
        EXEC:    result_q <= bus.alu_result;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Status flags follow the value written back; NOP leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else if (state_q == WB && op_q != OP_NOP) begin
      zero_flag <= (result_q == '0);
      neg_flag  <= result_q[DATA_W-1];
    end
  end
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a vector table of single commands plus
// hand-written sequences for reset mid-command, aliasing, NOP and handshake.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic [2:0]  op_code;
  logic        busy, done;
  logic [31:0] result;
`ifdef ALU_SEQ_FLAGS_EN
  logic        zero_flag, neg_flag;
`endif

  int checks = 0;
  int errors = 0;

  alu_sequencer_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  alu_sequencer #(.DATA_W(32), .NREGS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .op_code(op_code), .busy(busy), .done(done), .result(result)
`ifdef ALU_SEQ_FLAGS_EN
    , .zero_flag(zero_flag), .neg_flag(neg_flag)
`endif
  );

  always #5 clk = ~clk;

  // External ALU model; NOP yields zero so a stray writeback is visible.
  always_comb begin
    case (bus.alu_op_code)
      4'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
      4'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
      4'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
      4'd3:    bus.alu_result = bus.alu_a | bus.alu_b;
      4'd4:    bus.alu_result = ~bus.alu_a;
      4'd5:    bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'd6:    bus.alu_result = bus.alu_a;
      default: bus.alu_result = 32'h0;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  a, b, d;
    logic [31:0] va, vb, exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic read_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(nm, rd_data, exp);
  endtask

  // Issues one command, returns the number of negedges from accept to done,
  // then waits out the WB edge so the writeback is visible.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, output int lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd = {op, a, b, d};
    chk("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    logic d_seen;

    vecs[0] = '{3'b000, 3'd1, 3'd2, 3'd3, 32'd5,         32'd7,         32'd12};
    vecs[1] = '{3'b001, 3'd1, 3'd2, 3'd4, 32'd0,         32'd1,         32'hFFFFFFFF};
    vecs[2] = '{3'b010, 3'd1, 3'd2, 3'd5, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200};
    vecs[3] = '{3'b011, 3'd6, 3'd7, 3'd1, 32'hA0000001, 32'h05000010, 32'hA5000011};
    vecs[4] = '{3'b101, 3'd1, 3'd2, 3'd3, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
    vecs[5] = '{3'b110, 3'd2, 3'd7, 3'd0, 32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF};
    vecs[6] = '{3'b000, 3'd1, 3'd2, 3'd5, 32'hFFFFFFFF, 32'd2,         32'd1};
    vecs[7] = '{3'b001, 3'd1, 3'd2, 3'd6, 32'd9,         32'd9,         32'd0};

    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    bus.cmd_valid = 1'b0; bus.cmd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst_result", result, 32'd0);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].a, vecs[i].va);
      load(vecs[i].b, vecs[i].vb);
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd3);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp);
      read_chk($sformatf("v%0d_reg", i), vecs[i].d, vecs[i].exp);
`ifdef ALU_SEQ_FLAGS_EN
      chk($sformatf("v%0d_zero", i), {31'b0, zero_flag}, {31'b0, vecs[i].exp == 32'd0});
      chk($sformatf("v%0d_neg", i), {31'b0, neg_flag}, {31'b0, vecs[i].exp[31]});
`endif
    end

    // NOT with dst aliasing srcA; r0 is nonzero so the forced zero on B shows.
    load(3'd0, 32'h00000055);
    load(3'd5, 32'h0000FFFF);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd = {3'b100, 3'd5, 3'd0, 3'd5};
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("not_alu_b", bus.alu_b, 32'd0);
    chk("not_alu_a", bus.alu_a, 32'h0000FFFF);
    chk("not_opcode", {28'b0, bus.alu_op_code}, 32'd4);
    @(negedge clk);
    chk("not_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    read_chk("not_r5", 3'd5, 32'hFFFF0000);

    // NOP: done pulses, r1 and flags keep their values.
    load(3'd1, 32'h00001234);
    run_cmd(3'b111, 3'd1, 3'd2, 3'd1, lat);
    chk("nop_latency", lat, 32'd3);
    read_chk("nop_r1", 3'd1, 32'h00001234);
`ifdef ALU_SEQ_FLAGS_EN
    chk("nop_zero", {31'b0, zero_flag}, 32'd0);
    chk("nop_neg", {31'b0, neg_flag}, 32'd1);
`endif

    // Handshake: load wins over a pending command, then two back-to-back commands.
    load(3'd1, 32'd3);
    load(3'd6, 32'h66);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'd4;
    bus.cmd_valid = 1'b1; bus.cmd = {3'b000, 3'd1, 3'd2, 3'd3};
    #1;
    chk("hs_ready_during_load", {31'b0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("hs_not_accepted", {31'b0, busy}, 32'd0);
    ld_en = 1'b0;
    read_chk("hs_load_r2", 3'd2, 32'd4);
    chk("hs_ready_after_load", {31'b0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("hs_done_%0d", k), {31'b0, done}, {31'b0, (k == 3 || k == 7)});
      chk($sformatf("hs_ready_%0d", k), {31'b0, bus.cmd_ready}, {31'b0, (k == 4 || k == 8)});
      chk($sformatf("hs_busy_%0d", k), {31'b0, busy}, {31'b0, !(k == 4 || k == 8)});
      if (k == 1) bus.cmd = {3'b001, 3'd2, 3'd1, 3'd4};
      if (k == 2) begin ld_en = 1'b1; ld_addr = 3'd6; ld_data = 32'hBAD; end
      if (k == 3) ld_en = 1'b0;
      if (k == 5) bus.cmd_valid = 1'b0;
    end
    read_chk("hs_r3", 3'd3, 32'd7);
    read_chk("hs_r4", 3'd4, 32'd1);
    read_chk("hs_r6_no_busy_load", 3'd6, 32'h66);

    // Reset asserted during EXEC of an ADD drops the command.
    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    load(3'd3, 32'hAAAA);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd = {3'b000, 3'd1, 3'd2, 3'd3};
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before", {31'b0, busy}, 32'd1);
    chk("mid_alu_a_before", bus.alu_a, 32'd5);
    #1 reset = 1'b1;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    chk("mid_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("mid_alu_a", bus.alu_a, 32'd0);
    chk("mid_alu_b", bus.alu_b, 32'd0);
    chk("mid_result", result, 32'd0);
    chk("mid_op_code", {29'b0, op_code}, 32'd0);
    chk("mid_alu_op", {28'b0, bus.alu_op_code}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("mid_zero", {31'b0, zero_flag}, 32'd0);
    chk("mid_neg", {31'b0, neg_flag}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    d_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) d_seen = 1'b1;
    end
    chk("mid_no_done", {31'b0, d_seen}, 32'd0);
    for (int r = 0; r < 8; r++) read_chk($sformatf("mid_reg%0d", r), r[2:0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
